fastram_burst: RTL and testbench

FASTRAM_BURST -- requirements
Module: fastram_burst

---
 rtl/fastram_burst_pkg.sv | 37 +++
 rtl/fastram_lanes.sv | 29 ++
 rtl/fastram_burst.sv | 188 ++++++++++++++++++
 tb/tb_fastram_burst.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fastram_burst_pkg.sv
// Shared definitions for the 68030 fast RAM burst controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package fastram_burst_pkg;

    // Controller state encoding.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT       = 3'd1,
        ST_TERM       = 3'd2,
        ST_BURST_WAIT = 3'd3,
        ST_BURST_TERM = 3'd4,
        ST_RECOVER    = 3'd5
    } state_t;

    // 68030 SIZ encodings.
    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    // Largest supported wait-state count (the counter is 2 bits wide).
    localparam int MAX_WAIT_STATES = 3;

    // Transfer length in bytes for a SIZ code.
    function automatic logic [2:0] siz_len(input logic [1:0] siz);
        logic [2:0] len;
        case (siz)
            SIZ_BYTE:  len = 3'd1;
            SIZ_WORD:  len = 3'd2;
            SIZ_3BYTE: len = 3'd3;
            default:   len = 3'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fastram_lanes.sv
// Byte-lane decode: A[1:0]/SIZ to active-low RAM byte selects.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers the result.
// Ports: a (A[1:0]), siz (SIZ), lane_n (lane_n[3] = D31:24, low = selected).
module fastram_lanes
    import fastram_burst_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] siz,
    output logic [3:0] lane_n
);

    logic [2:0] first_b;
    logic [2:0] last_b;

    // Byte offset 0 lives on lane 3 (big-endian bus). Transfers running past
    // offset 3 are clipped; the CPU issues the remainder as a further cycle.
    always_comb begin
        first_b = {1'b0, a};
        last_b  = first_b + siz_len(siz) - 3'd1;
        lane_n  = 4'hF;
        for (int off = 0; off < 4; off++) begin
            if ((3'(off) >= first_b) && (3'(off) <= last_b)) begin
                lane_n[2'(3 - off)] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fastram_burst.sv
// 68030 synchronous fast RAM controller with cache burst fills (STERM/CBACK).
// Latency: first STERM WAIT_STATES+1 cycles after AS20 sampled, burst beats every WAIT_STATES+1.
// Backpressure: none; AS20 negation aborts, CBREQ negation ends a burst at the current beat.
// Ports: CLKCPU/RESET; CPU side ACCESS, BANK, A, A32, SIZ, AS20, DS20, RW20, CBREQ in,
//        STERM, CBACK, CIIN out; RAM side RAMA, RAMCS, RAMOE, RAMWE, BANKCE out.
//        A32 carries CPU A[3:2], the longword index that seeds RAMA.
module fastram_burst #(
    parameter int WAIT_STATES = 1,
    parameter int BURST_EN    = 1,
    parameter int BANKS       = 2
) (
    input  logic                                           CLKCPU,
    input  logic                                           RESET,
    input  logic                                           ACCESS,
    input  logic [((BANKS > 1) ? $clog2(BANKS) : 1) - 1:0] BANK,
    input  logic [1:0]                                     A,
    input  logic [1:0]                                     A32,
    input  logic [1:0]                                     SIZ,
    input  logic                                           AS20,
    input  logic                                           DS20,
    input  logic                                           RW20,
    input  logic                                           CBREQ,
    output logic                                           STERM,
    output logic                                           CBACK,
    output logic                                           CIIN,
    output logic [1:0]                                     RAMA,
    output logic [3:0]                                     RAMCS,
    output logic                                           RAMOE,
    output logic                                           RAMWE,
    output logic [BANKS-1:0]                               BANKCE
);
    import fastram_burst_pkg::*;

    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int WS     = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic [1:0]         rama_q, rama_d;
    logic [1:0]         beat_q, beat_d;
    logic               rw_q, rw_d;
    logic [3:0]         lanes_q, lanes_d;
    logic               sterm_q, sterm_d;
    logic               cback_q, cback_d;
    logic [3:0]         ramcs_q, ramcs_d;
    logic               ramoe_q, ramoe_d;
    logic               ramwe_q, ramwe_d;
    logic [BANKS-1:0]   bankce_q, bankce_d;

    logic               bank_ok;
    logic [3:0]         lane_dec;
    logic               active_d;
    logic               term_d;

    fastram_lanes u_lanes (
        .a      (A),
        .siz    (SIZ),
        .lane_n (lane_dec)
    );

    // A non-existent bank never starts a cycle, so no STERM is ever given
    // and the CPU's bus timeout ends it.
    assign bank_ok = (int'(BANK) < BANKS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        rama_d  = rama_q;
        beat_d  = beat_q;
        rw_d    = rw_q;
        lanes_d = lanes_q;

        case (state_q)
            ST_IDLE: begin
                if (!AS20 && !ACCESS && bank_ok) begin
                    bank_d  = BANK;
                    rama_d  = A32;
                    rw_d    = RW20;
                    lanes_d = lane_dec;
                    beat_d  = 2'd0;
                    if (WS == 0) begin
                        state_d = ST_TERM;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 2'(WS);
                    end
                end
            end
            ST_WAIT, ST_BURST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = (state_q == ST_WAIT) ? ST_TERM : ST_BURST_TERM;
                end
            end
            ST_TERM, ST_BURST_TERM: begin
                // CBACK given with this beat's STERM means the CPU expects
                // another beat; otherwise the cycle is complete.
                if (!cback_q) begin
                    beat_d = beat_q + 2'd1;
                    rama_d = rama_q + 2'd1;
                    if (WS == 0) begin
                        state_d = ST_BURST_TERM;
                    end else begin
                        state_d = ST_BURST_WAIT;
                        cnt_d   = 2'(WS);
                    end
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (AS20) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Address strobe negated: the CPU has abandoned the cycle.
        if ((state_q != ST_IDLE) && AS20) begin
            state_d = ST_IDLE;
        end

        // Outputs are decoded from the next state and registered.
        active_d = state_d inside {ST_WAIT, ST_TERM, ST_BURST_WAIT, ST_BURST_TERM};
        term_d   = state_d inside {ST_TERM, ST_BURST_TERM};
        sterm_d  = !term_d;

        cback_d = 1'b1;
        if (BURST_EN != 0) begin
            if (state_d == ST_TERM) begin
                cback_d = !(rw_d && !CBREQ);
            end else if (state_d == ST_BURST_TERM) begin
                // Fourth beat (index 3) always ends the burst.
                cback_d = !(!CBREQ && (beat_d != 2'd3));
            end
        end

        ramcs_d  = active_d ? (rw_d ? 4'h0 : lanes_d) : 4'hF;
        ramoe_d  = !(active_d && rw_d);
        ramwe_d  = !(active_d && !rw_d && !DS20);
        bankce_d = active_d ? ~(BANKS'(1) << bank_d) : '1;
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            bank_q   <= '0;
            rama_q   <= 2'd0;
            beat_q   <= 2'd0;
            rw_q     <= 1'b1;
            lanes_q  <= 4'hF;
            sterm_q  <= 1'b1;
            cback_q  <= 1'b1;
            ramcs_q  <= 4'hF;
            ramoe_q  <= 1'b1;
            ramwe_q  <= 1'b1;
            bankce_q <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            rama_q   <= rama_d;
            beat_q   <= beat_d;
            rw_q     <= rw_d;
            lanes_q  <= lanes_d;
            sterm_q  <= sterm_d;
            cback_q  <= cback_d;
            ramcs_q  <= ramcs_d;
            ramoe_q  <= ramoe_d;
            ramwe_q  <= ramwe_d;
            bankce_q <= bankce_d;
        end
    end

    assign STERM  = sterm_q;
    assign CBACK  = cback_q;
    assign CIIN   = 1'b1;      // fast RAM is always cacheable
    assign RAMA   = rama_q;
    assign RAMCS  = ramcs_q;
    assign RAMOE  = ramoe_q;
    assign RAMWE  = ramwe_q;
    assign BANKCE = bankce_q;

endmodule

// File: tb/tb_fastram_burst.sv
// Bench for fastram_burst: two instances (WAIT_STATES=1 and 0) share stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_fastram_burst;

    localparam int NC = 12;   // cycles captured per transaction
    // {STERM, CBACK, CIIN, RAMCS, RAMOE, RAMWE, BANKCE, RAMA}
    localparam logic [12:0] RST_V = 13'b1_1_1_1111_1_1_11_00;

    logic       CLKCPU, RESET, ACCESS, AS20, DS20, RW20, CBREQ;
    logic [0:0] BANK;
    logic [1:0] A, A32, SIZ;

    logic       sterm [2], cback [2], ciin [2], ramoe [2], ramwe [2];
    logic [1:0] rama [2], bankce [2];
    logic [3:0] ramcs [2];
    logic [12:0] pk [2];

    assign pk[0] = {sterm[0], cback[0], ciin[0], ramcs[0], ramoe[0], ramwe[0], bankce[0], rama[0]};
    assign pk[1] = {sterm[1], cback[1], ciin[1], ramcs[1], ramoe[1], ramwe[1], bankce[1], rama[1]};

    // index 0: one wait state, index 1: zero wait states
    fastram_burst #(.WAIT_STATES(1), .BURST_EN(1), .BANKS(2)) u_ws1 (
        .CLKCPU(CLKCPU), .RESET(RESET), .ACCESS(ACCESS), .BANK(BANK), .A(A), .A32(A32),
        .SIZ(SIZ), .AS20(AS20), .DS20(DS20), .RW20(RW20), .CBREQ(CBREQ),
        .STERM(sterm[0]), .CBACK(cback[0]), .CIIN(ciin[0]), .RAMA(rama[0]),
        .RAMCS(ramcs[0]), .RAMOE(ramoe[0]), .RAMWE(ramwe[0]), .BANKCE(bankce[0])
    );

    fastram_burst #(.WAIT_STATES(0), .BURST_EN(1), .BANKS(2)) u_ws0 (
        .CLKCPU(CLKCPU), .RESET(RESET), .ACCESS(ACCESS), .BANK(BANK), .A(A), .A32(A32),
        .SIZ(SIZ), .AS20(AS20), .DS20(DS20), .RW20(RW20), .CBREQ(CBREQ),
        .STERM(sterm[1]), .CBACK(cback[1]), .CIIN(ciin[1]), .RAMA(rama[1]),
        .RAMCS(ramcs[1]), .RAMOE(ramoe[1]), .RAMWE(ramwe[1]), .BANKCE(bankce[1])
    );

    initial CLKCPU = 1'b0;
    always #5 CLKCPU = ~CLKCPU;

    // Transaction descriptor. Edge 0 is the rising edge that samples AS20 low;
    // *_rel / *_edge give the first edge at which that input has changed.
    int t_a32, t_a, t_siz, t_rw, t_bank;
    int t_cbreq_req, t_cbreq_rel, t_ds_edge, t_as_rel;

    logic [12:0] obs  [2][NC];
    logic [12:0] expv [2][NC];
    logic [12:0] msk  [2][NC];

    int n_vec, n_err;

    function automatic bit cbreq_low(input int e);
        return (t_cbreq_req != 0) && (e < t_cbreq_rel);
    endfunction

    function automatic bit ds_low(input int e);
        return e >= t_ds_edge;
    endfunction

    // Lane n selected when byte offset 3-n falls inside the transfer.
    function automatic logic [3:0] exp_lanes(input int a, input int siz);
        int len, m;
        logic [3:0] r;
        len = (siz == 0) ? 4 : siz;
        m   = (((1 << len) - 1) << a) & 15;
        for (int n = 0; n < 4; n++) r[n] = !m[3 - n];
        return r;
    endfunction

    task automatic set_idle();
        AS20 = 1'b1; ACCESS = 1'b1; DS20 = 1'b1; CBREQ = 1'b1; RW20 = 1'b1;
        A = 2'd0; SIZ = 2'd0; A32 = 2'd0; BANK = 1'b0;
    endtask

    task automatic set_inputs(input int e);
        AS20   = (e >= t_as_rel) ? 1'b1 : 1'b0;
        ACCESS = 1'b0;
        DS20   = ds_low(e) ? 1'b0 : 1'b1;
        CBREQ  = cbreq_low(e) ? 1'b0 : 1'b1;
        RW20   = (t_rw != 0);
        A      = 2'(t_a);
        SIZ    = 2'(t_siz);
        A32    = 2'(t_a32);
        BANK   = 1'(t_bank);
    endtask

    task automatic run_txn();
        @(negedge CLKCPU);
        set_inputs(0);
        for (int e = 0; e < NC; e++) begin
            @(posedge CLKCPU);
            @(negedge CLKCPU);
            obs[0][e] = pk[0];
            obs[1][e] = pk[1];
            set_inputs(e + 1);
        end
        set_idle();
        repeat (2) @(negedge CLKCPU);
    endtask

    // Expected outputs after each edge, from the bus rules: beat k terminates
    // at edge k*(ws+1)+ws; a beat carries CBACK when the burst continues.
    task automatic build_model();
        for (int d = 0; d < 2; d++) begin
            int ws, p, nb, lastedge, k;
            bit cbk [4];
            bit going, act, term, cbx;
            logic [3:0] cs;
            logic [1:0] bce;
            ws = (d == 0) ? 1 : 0;
            p  = ws + 1;
            nb = 0;
            going = 1'b1;
            for (int b = 0; b < 4; b++) begin
                cbk[b] = 1'b0;
                if (going) begin
                    nb = b + 1;
                    if (b == 0) cbk[b] = (t_rw != 0) && cbreq_low(ws);
                    else        cbk[b] = (b < 3) && cbreq_low(b * p + ws);
                    going = cbk[b];
                end
            end
            lastedge = (nb - 1) * p + ws;
            for (int e = 0; e < NC; e++) begin
                act  = (e <= lastedge) && (e < t_as_rel);
                term = act && ((e % p) == ws);
                k    = e / p;
                cbx  = 1'b0;
                if (term) cbx = cbk[k];
                cs  = act ? ((t_rw != 0) ? 4'h0 : exp_lanes(t_a, t_siz)) : 4'hF;
                bce = act ? ~(2'b01 << t_bank) : 2'b11;
                expv[d][e] = {!term, !cbx, 1'b1, cs, !(act && t_rw != 0),
                              !(act && t_rw == 0 && ds_low(e)), bce, 2'(t_a32 + k)};
                msk[d][e]  = act ? 13'h1FFF : 13'h1FFC;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLKCPU);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (pk[d] !== RST_V) begin
                n_err++;
                $display("FAIL reset ws=%0d got=%b exp=%b", 1 - d, pk[d], RST_V);
            end
        end
        RESET = 1'b1;
        repeat (2) @(negedge CLKCPU);
    endtask

    task automatic test_read_single();
        t_a32 = 1; t_a = 0; t_siz = 0; t_rw = 1; t_bank = 1;
        t_cbreq_req = 0; t_cbreq_rel = 0; t_ds_edge = 0; t_as_rel = 10;
        run_txn();
        build_model();
        for (int d = 0; d < 2; d++) for (int e = 0; e < NC; e++) begin
            n_vec++;
            if ((obs[d][e] & msk[d][e]) !== (expv[d][e] & msk[d][e])) begin
                n_err++;
                $display("FAIL read_single ws=%0d edge=%0d got=%b exp=%b", 1 - d, e, obs[d][e], expv[d][e]);
            end
        end
    endtask

    task automatic test_burst_read();
        logic [1:0] seq [4];
        seq[0] = 2'd2; seq[1] = 2'd3; seq[2] = 2'd0; seq[3] = 2'd1;
        t_a32 = 2; t_a = 0; t_siz = 0; t_rw = 1; t_bank = 0;
        t_cbreq_req = 1; t_cbreq_rel = 99; t_ds_edge = 0; t_as_rel = 10;
        run_txn();
        build_model();
        for (int d = 0; d < 2; d++) for (int e = 0; e < NC; e++) begin
            n_vec++;
            if ((obs[d][e] & msk[d][e]) !== (expv[d][e] & msk[d][e])) begin
                n_err++;
                $display("FAIL burst_read ws=%0d edge=%0d got=%b exp=%b", 1 - d, e, obs[d][e], expv[d][e]);
            end
        end
        // zero-wait instance: STERM low on four consecutive cycles with RAMA 2,3,0,1
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({obs[1][i][12], obs[1][i][1:0]} !== {1'b0, seq[i]}) begin
                n_err++;
                $display("FAIL burst_rama beat=%0d got=%b exp=%b", i, {obs[1][i][12], obs[1][i][1:0]}, {1'b0, seq[i]});
            end
        end
    endtask

    task automatic test_byte_write();
        t_a32 = 0; t_a = 1; t_siz = 1; t_rw = 0; t_bank = 1;
        t_cbreq_req = 1; t_cbreq_rel = 99; t_ds_edge = 1; t_as_rel = 10;
        run_txn();
        build_model();
        for (int d = 0; d < 2; d++) for (int e = 0; e < NC; e++) begin
            n_vec++;
            if ((obs[d][e] & msk[d][e]) !== (expv[d][e] & msk[d][e])) begin
                n_err++;
                $display("FAIL byte_write ws=%0d edge=%0d got=%b exp=%b", 1 - d, e, obs[d][e], expv[d][e]);
            end
        end
    endtask

    task automatic test_word_write();
        t_a32 = 3; t_a = 3; t_siz = 2; t_rw = 0; t_bank = 0;
        t_cbreq_req = 0; t_cbreq_rel = 0; t_ds_edge = 0; t_as_rel = 10;
        run_txn();
        build_model();
        for (int d = 0; d < 2; d++) for (int e = 0; e < NC; e++) begin
            n_vec++;
            if ((obs[d][e] & msk[d][e]) !== (expv[d][e] & msk[d][e])) begin
                n_err++;
                $display("FAIL word_write ws=%0d edge=%0d got=%b exp=%b", 1 - d, e, obs[d][e], expv[d][e]);
            end
        end
    endtask

    task automatic test_cbreq_early();
        t_a32 = 3; t_a = 0; t_siz = 0; t_rw = 1; t_bank = 1;
        t_cbreq_req = 1; t_cbreq_rel = 2; t_ds_edge = 0; t_as_rel = 10;
        run_txn();
        build_model();
        for (int d = 0; d < 2; d++) for (int e = 0; e < NC; e++) begin
            n_vec++;
            if ((obs[d][e] & msk[d][e]) !== (expv[d][e] & msk[d][e])) begin
                n_err++;
                $display("FAIL cbreq_early ws=%0d edge=%0d got=%b exp=%b", 1 - d, e, obs[d][e], expv[d][e]);
            end
        end
    endtask

    task automatic test_abort();
        t_a32 = 0; t_a = 0; t_siz = 0; t_rw = 1; t_bank = 0;
        t_cbreq_req = 1; t_cbreq_rel = 99; t_ds_edge = 0; t_as_rel = 2;
        run_txn();
        build_model();
        for (int d = 0; d < 2; d++) for (int e = 0; e < NC; e++) begin
            n_vec++;
            if ((obs[d][e] & msk[d][e]) !== (expv[d][e] & msk[d][e])) begin
                n_err++;
                $display("FAIL abort ws=%0d edge=%0d got=%b exp=%b", 1 - d, e, obs[d][e], expv[d][e]);
            end
        end
    endtask

    task automatic test_reset_mid();
        t_a32 = 1; t_a = 0; t_siz = 0; t_rw = 1; t_bank = 1;
        t_cbreq_req = 1; t_cbreq_rel = 99; t_ds_edge = 0; t_as_rel = 10;
        @(negedge CLKCPU);
        set_inputs(0);
        @(posedge CLKCPU);
        #2 RESET = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (pk[d] !== RST_V) begin
                n_err++;
                $display("FAIL reset_mid ws=%0d got=%b exp=%b", 1 - d, pk[d], RST_V);
            end
        end
        @(negedge CLKCPU);
        set_idle();
        @(negedge CLKCPU);
        RESET = 1'b1;
        repeat (2) @(negedge CLKCPU);
        t_cbreq_req = 0;
        run_txn();
        build_model();
        for (int d = 0; d < 2; d++) for (int e = 0; e < NC; e++) begin
            n_vec++;
            if ((obs[d][e] & msk[d][e]) !== (expv[d][e] & msk[d][e])) begin
                n_err++;
                $display("FAIL after_reset ws=%0d edge=%0d got=%b exp=%b", 1 - d, e, obs[d][e], expv[d][e]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            t_a32       = int'($urandom_range(0, 3));
            t_a         = int'($urandom_range(0, 3));
            t_siz       = int'($urandom_range(0, 3));
            t_rw        = int'($urandom_range(0, 1));
            t_bank      = int'($urandom_range(0, 1));
            t_cbreq_req = int'($urandom_range(0, 1));
            t_cbreq_rel = int'($urandom_range(1, 9));
            t_ds_edge   = int'($urandom_range(0, 3));
            t_as_rel    = ($urandom_range(0, 2) != 0) ? 11 : int'($urandom_range(1, 10));
            run_txn();
            build_model();
            for (int d = 0; d < 2; d++) for (int e = 0; e < NC; e++) begin
                n_vec++;
                if ((obs[d][e] & msk[d][e]) !== (expv[d][e] & msk[d][e])) begin
                    n_err++;
                    $display("FAIL random#%0d ws=%0d edge=%0d got=%b exp=%b", n, 1 - d, e, obs[d][e], expv[d][e]);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        set_idle();
        RESET = 1'b1;
        #1 RESET = 1'b0;
        test_reset();
        test_read_single();
        test_burst_read();
        test_byte_write();
        test_word_write();
        test_cbreq_early();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
